// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- pipeline stage register / in-order skid FIFO with the
// valid / allow_in handshake, a stage-local ready_go stall and a synchronous
// flush.
//
//   DEPTH == 1 : classic single-register stage. allow_in looks through to
//                next_allow_in, so a full stage can still take a beat while
//                its head leaves.
//   DEPTH  > 1 : FIFO of DEPTH entries. allow_in depends on registered
//                state only, which cuts the combinational allow_in chain.
//                There is no full bypass and no empty fall-through.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   prev_to_valid     upstream beat valid
//   prev_data         upstream payload
//   allow_in          this stage accepts a beat this cycle
//   ready_go          head entry may leave
//   next_allow_in     downstream accepts
//   to_next_valid     beat offered downstream
//   to_next_data      head payload
//   flush             synchronous flush; beats held and incoming are dropped
//   occupancy         entries currently held
//   stall_cnt         (PIPE_STAGE_PERF_EN only) cycles with data held and no pop
//
// Build option
//   PIPE_STAGE_PERF_EN  adds the saturating stall_cnt[31:0] output.
module pipe_stage_buf #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             prev_to_valid,
   input  logic [WIDTH-1:0] prev_data,
   output logic             allow_in,
   input  logic             ready_go,
   input  logic             next_allow_in,
   output logic             to_next_valid,
   output logic [WIDTH-1:0] to_next_data,
   input  logic             flush,
   output logic [CNT_W-1:0] occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);

   // A 1-entry stage still gets a 1-bit pointer; ptr_inc pins it to 0.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] entry [DEPTH];
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic             not_empty, push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign not_empty     = (count != '0);
   assign to_next_valid = not_empty && ready_go && !flush;
   assign to_next_data  = entry[rd_ptr];
   assign occupancy     = count;

   generate
      if (DEPTH == 1) begin : g_single
         // A full register frees up in the same cycle its beat leaves.
         assign allow_in = !not_empty || (ready_go && next_allow_in);
      end else begin : g_fifo
         assign allow_in = (count != CNT_W'(DEPTH));
      end
   endgenerate

   // flush wins over both sides of the handshake.
   assign push = prev_to_valid && allow_in && !flush;
   assign pop  = to_next_valid && next_allow_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // Entry contents after a flush are stale but unreachable: count is 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      end else if (push) begin
         entry[wr_ptr] <= prev_data;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   // Counts cycles where something is held but nothing leaves; survives flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (not_empty && !pop && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule
